// File: rtl/bf16_add_unpack.sv
// Splits bf16 operand pairs into fields and resolves zero/subnormal/inf/NaN bypass results.
// Latency: one cycle from accept to out_valid_o when the buffer is empty.
// Backpressure: 2-entry skid buffer; in_ready_o is registered and drops only when both entries are full.
module bf16_add_unpack #(
    parameter int E = 8,
    parameter int M = 7
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [1+E+M-1:0] a_i,
    input  logic [1+E+M-1:0] b_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic             sa_o,
    output logic             sb_o,
    output logic [E-1:0]     ea_o,
    output logic [E-1:0]     eb_o,
    output logic [M-1:0]     ma_o,
    output logic [M-1:0]     mb_o,
    output logic             bypass_o,
    output logic [1+E+M-1:0] bypass_res_o
);
    localparam int W = 1 + E + M;

    // Canonical quiet NaN: positive, all-ones exponent, mantissa MSB set.
    localparam logic [W-1:0] QNAN = {1'b0, {E{1'b1}}, 1'b1, {(M-1){1'b0}}};

    typedef struct packed {
        logic         sa;
        logic         sb;
        logic [E-1:0] ea;
        logic [E-1:0] eb;
        logic [M-1:0] ma;
        logic [M-1:0] mb;
        logic         bypass;
        logic [W-1:0] res;
    } pair_t;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t state, state_nxt;
    pair_t  r0, r1, unp;
    logic   load_r0, load_r1, move_r1;
    logic   accept, pop;

    // Raw field views of both operands.
    logic         sa, sb;
    logic [E-1:0] ea, eb;
    logic [M-1:0] ma, mb;
    logic         za, zb, ia, ib, na, nb;

    assign sa = a_i[W-1];
    assign sb = b_i[W-1];
    assign ea = a_i[W-2 -: E];
    assign eb = b_i[W-2 -: E];
    assign ma = a_i[M-1:0];
    assign mb = b_i[M-1:0];

    // Subnormals count as zero, so zero depends only on the exponent.
    assign za = (ea == '0);
    assign zb = (eb == '0);
    assign ia = (&ea) && (ma == '0);
    assign ib = (&eb) && (mb == '0);
    assign na = (&ea) && (ma != '0);
    assign nb = (&eb) && (mb != '0);

    assign accept = in_valid_i && in_ready_o;
    assign pop    = out_valid_o && out_ready_i;

    // Classify the incoming pair and pick the special-case result, first rule wins.
    always_comb begin
        unp        = '0;
        unp.sa     = sa;
        unp.sb     = sb;
        unp.ea     = ea;
        unp.eb     = eb;
        unp.ma     = za ? '0 : ma;
        unp.mb     = zb ? '0 : mb;
        unp.bypass = 1'b1;
        if (na || nb || (ia && ib && (sa != sb))) begin
            unp.res = QNAN;
        end else if (ia) begin
            unp.res = a_i;
        end else if (ib) begin
            unp.res = b_i;
        end else if (za && zb) begin
            unp.res = {sa & sb, {(W-1){1'b0}}};
        end else if (za) begin
            unp.res = b_i;
        end else if (zb) begin
            unp.res = a_i;
        end else begin
            unp.bypass = 1'b0;
            unp.res    = '0;
        end
    end

    // State register plus registered ready derived from the next state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= EMPTY;
            in_ready_o <= 1'b1;
        end else begin
            state      <= state_nxt;
            in_ready_o <= (state_nxt != FULL);
        end
    end

    // Skid-buffer next state and register load controls.
    always_comb begin
        state_nxt = state;
        load_r0   = 1'b0;
        load_r1   = 1'b0;
        move_r1   = 1'b0;
        case (state)
            EMPTY: begin
                if (accept) begin
                    load_r0   = 1'b1;
                    state_nxt = ONE;
                end
            end
            ONE: begin
                if (accept && pop) begin
                    load_r0 = 1'b1;
                end else if (accept) begin
                    load_r1   = 1'b1;
                    state_nxt = FULL;
                end else if (pop) begin
                    state_nxt = EMPTY;
                end
            end
            FULL: begin
                if (pop) begin
                    move_r1   = 1'b1;
                    state_nxt = ONE;
                end
            end
            default: state_nxt = EMPTY;
        endcase
    end

    // Main and skid data registers; reset clears them so outputs read zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            r0 <= '0;
            r1 <= '0;
        end else begin
            if (load_r0) begin
                r0 <= unp;
            end else if (move_r1) begin
                r0 <= r1;
            end
            if (load_r1) begin
                r1 <= unp;
            end
        end
    end

    assign out_valid_o  = (state != EMPTY);
    assign sa_o         = r0.sa;
    assign sb_o         = r0.sb;
    assign ea_o         = r0.ea;
    assign eb_o         = r0.eb;
    assign ma_o         = r0.ma;
    assign mb_o         = r0.mb;
    assign bypass_o     = r0.bypass;
    assign bypass_res_o = r0.res;

endmodule

// File: tb/tb_bf16_add_unpack.sv
// Self-checking bench for bf16_add_unpack: directed special cases, backpressure,
// reset while full, and a long randomized run against a scoreboard model.
module tb_bf16_add_unpack;

    typedef struct packed {
        logic        sa;
        logic        sb;
        logic [7:0]  ea;
        logic [7:0]  eb;
        logic [6:0]  ma;
        logic [6:0]  mb;
        logic        byp;
        logic [15:0] res;
    } res_t;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a, b;
    logic        out_valid;
    logic        out_ready;
    logic        sa_o, sb_o;
    logic [7:0]  ea_o, eb_o;
    logic [6:0]  ma_o, mb_o;
    logic        bypass_o;
    logic [15:0] bypass_res_o;
    res_t        obs;

    int total = 0;
    int bad   = 0;

    bf16_add_unpack dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid_i   (in_valid),
        .in_ready_o   (in_ready),
        .a_i          (a),
        .b_i          (b),
        .out_valid_o  (out_valid),
        .out_ready_i  (out_ready),
        .sa_o         (sa_o),
        .sb_o         (sb_o),
        .ea_o         (ea_o),
        .eb_o         (eb_o),
        .ma_o         (ma_o),
        .mb_o         (mb_o),
        .bypass_o     (bypass_o),
        .bypass_res_o (bypass_res_o)
    );

    assign obs = {sa_o, sb_o, ea_o, eb_o, ma_o, mb_o, bypass_o, bypass_res_o};

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference model: classify each operand, then apply the bypass rules in order.
    localparam int K_ZERO = 0, K_INF = 1, K_NAN = 2, K_NORM = 3;

    function automatic int kind(input logic [15:0] x);
        if (x[14:7] == 8'd0)   return K_ZERO;
        if (x[14:7] == 8'd255) return (x[6:0] == 7'd0) ? K_INF : K_NAN;
        return K_NORM;
    endfunction

    function automatic res_t model(input logic [15:0] x, input logic [15:0] y);
        res_t r;
        int   kx, ky;
        kx    = kind(x);
        ky    = kind(y);
        r.sa  = x[15];
        r.sb  = y[15];
        r.ea  = x[14:7];
        r.eb  = y[14:7];
        r.ma  = (kx == K_ZERO) ? 7'd0 : x[6:0];
        r.mb  = (ky == K_ZERO) ? 7'd0 : y[6:0];
        r.byp = 1'b1;
        if (kx == K_NAN || ky == K_NAN || (kx == K_INF && ky == K_INF && x[15] != y[15]))
            r.res = 16'h7FC0;
        else if (kx == K_INF)
            r.res = x;
        else if (ky == K_INF)
            r.res = y;
        else if (kx == K_ZERO && ky == K_ZERO)
            r.res = (x[15] && y[15]) ? 16'h8000 : 16'h0000;
        else if (kx == K_ZERO)
            r.res = y;
        else if (ky == K_ZERO)
            r.res = x;
        else begin
            r.byp = 1'b0;
            r.res = 16'h0000;
        end
        return r;
    endfunction

    // The sum result is meaningless without bypass, so ignore it there.
    function automatic res_t mask(input res_t x);
        res_t r;
        r = x;
        if (!r.byp) r.res = 16'h0000;
        return r;
    endfunction

    // Operands biased toward zero/subnormal, inf and NaN exponents.
    function automatic logic [15:0] rand_op();
        logic [7:0] e;
        logic [6:0] m;
        case ($urandom % 4)
            0:       e = 8'h00;
            1:       e = 8'hFF;
            default: e = 8'($urandom);
        endcase
        m = (($urandom % 3) == 0) ? 7'd0 : 7'($urandom);
        return {1'($urandom), e, m};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Push one pair into an empty stage, capture the output a cycle later, then drain it.
    task automatic xfer_one(input logic [15:0] x, input logic [15:0] y,
                            output res_t o, output logic vld);
        in_valid  = 1'b1;
        a         = x;
        b         = y;
        out_ready = 1'b0;
        step();
        in_valid  = 1'b0;
        vld       = out_valid;
        o         = obs;
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst      = 1'b1;
        in_valid = 1'b1;
        a        = rand_op();
        b        = rand_op();
        step();
        step();
        total++;
        if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        total++;
        if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
        total++;
        if (obs !== res_t'(0)) begin bad++; $display("FAIL reset_data got=%h exp=0", obs); end
        rst      = 1'b0;
        in_valid = 1'b0;
        step();
        total++;
        if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_no_accept got=%b exp=0", out_valid); end
    endtask

    task automatic test_specials();
        logic [15:0] ta [10];
        logic [15:0] tbv[10];
        logic [15:0] tr [10];
        logic        tbp[10];
        res_t        o;
        logic        vld;
        ta = '{16'h3F80, 16'h7F80, 16'h7F80, 16'h7FC1, 16'h0001,
               16'h8000, 16'h0000, 16'hFF80, 16'h3F80, 16'h8001};
        tbv = '{16'h4000, 16'hFF80, 16'h3F80, 16'h3F80, 16'hC040,
                16'h8000, 16'h8000, 16'hFF80, 16'hBF80, 16'h8000};
        tr = '{16'h0000, 16'h7FC0, 16'h7F80, 16'h7FC0, 16'hC040,
               16'h8000, 16'h0000, 16'hFF80, 16'h0000, 16'h8000};
        tbp = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
        for (int i = 0; i < 10; i++) begin
            xfer_one(ta[i], tbv[i], o, vld);
            total++;
            if (vld !== 1'b1) begin bad++; $display("FAIL spec%0d_latency got=%b exp=1", i, vld); end
            total++;
            if (o.byp !== tbp[i]) begin bad++; $display("FAIL spec%0d_bypass got=%b exp=%b", i, o.byp, tbp[i]); end
            if (tbp[i]) begin
                total++;
                if (o.res !== tr[i]) begin bad++; $display("FAIL spec%0d_res got=%h exp=%h", i, o.res, tr[i]); end
            end
            if (i == 0) begin
                total++;
                if ({o.sa, o.ea, o.ma, o.sb, o.eb, o.mb} !== {1'b0, 8'h7F, 7'h00, 1'b0, 8'h80, 7'h00}) begin
                    bad++;
                    $display("FAIL t1_fields got=%h exp=%h", {o.sa, o.ea, o.ma, o.sb, o.eb, o.mb},
                             {1'b0, 8'h7F, 7'h00, 1'b0, 8'h80, 7'h00});
                end
            end
            total++;
            if (mask(o) !== model(ta[i], tbv[i])) begin
                bad++;
                $display("FAIL spec%0d_model got=%h exp=%h", i, mask(o), model(ta[i], tbv[i]));
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] pa[3];
        logic [15:0] pb[3];
        res_t        e[3];
        int          k, cyc;
        logic        acc, pp;
        for (int i = 0; i < 3; i++) begin
            pa[i] = rand_op();
            pb[i] = rand_op();
            e[i]  = model(pa[i], pb[i]);
        end
        out_ready = 1'b0;
        in_valid  = 1'b1;
        a = pa[0]; b = pb[0];
        step();
        a = pa[1]; b = pb[1];
        total++;
        if (in_ready !== 1'b1) begin bad++; $display("FAIL bp_ready_one got=%b exp=1", in_ready); end
        step();
        a = pa[2]; b = pb[2];
        total++;
        if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_ready_full got=%b exp=0", in_ready); end
        total++;
        if (mask(obs) !== e[0]) begin bad++; $display("FAIL bp_head got=%h exp=%h", mask(obs), e[0]); end
        step();
        step();
        total++;
        if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_ready_hold got=%b exp=0", in_ready); end
        total++;
        if (out_valid !== 1'b1 || mask(obs) !== e[0]) begin
            bad++;
            $display("FAIL bp_stable got=%b/%h exp=1/%h", out_valid, mask(obs), e[0]);
        end
        out_ready = 1'b1;
        k   = 0;
        cyc = 0;
        while (k < 3 && cyc < 20) begin
            acc = in_valid && in_ready;
            pp  = out_valid && out_ready;
            if (pp) begin
                total++;
                if (mask(obs) !== e[k]) begin bad++; $display("FAIL bp_order%0d got=%h exp=%h", k, mask(obs), e[k]); end
                k++;
            end
            step();
            if (acc) in_valid = 1'b0;
            cyc++;
        end
        in_valid = 1'b0;
        total++;
        if (k != 3) begin bad++; $display("FAIL bp_count got=%0d exp=3", k); end
        step();
        total++;
        if (out_valid !== 1'b0) begin bad++; $display("FAIL bp_dup got=%b exp=0", out_valid); end
        out_ready = 1'b0;
    endtask

    task automatic test_reset_full();
        res_t        o;
        logic        vld;
        logic [15:0] x, y;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        a = rand_op(); b = rand_op();
        step();
        a = rand_op(); b = rand_op();
        step();
        in_valid = 1'b0;
        total++;
        if (in_ready !== 1'b0) begin bad++; $display("FAIL rf_full got=%b exp=0", in_ready); end
        rst = 1'b1;
        step();
        rst = 1'b0;
        total++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            bad++;
            $display("FAIL rf_after got=%b%b exp=01", out_valid, in_ready);
        end
        total++;
        if (obs !== res_t'(0)) begin bad++; $display("FAIL rf_data got=%h exp=0", obs); end
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            total++;
            if (out_valid !== 1'b0) begin bad++; $display("FAIL rf_stale%0d got=%b exp=0", i, out_valid); end
        end
        x = rand_op();
        y = rand_op();
        xfer_one(x, y, o, vld);
        total++;
        if (vld !== 1'b1 || mask(o) !== model(x, y)) begin
            bad++;
            $display("FAIL rf_fresh got=%b/%h exp=1/%h", vld, mask(o), model(x, y));
        end
        step();
        total++;
        if (out_valid !== 1'b0) begin bad++; $display("FAIL rf_drained got=%b exp=0", out_valid); end
    endtask

    task automatic test_random();
        localparam int N = 10000;
        res_t q[$];
        res_t prev_obs, exp_r;
        logic prev_stall, acc, pp;
        int   sent, rcvd, cyc;
        sent       = 0;
        rcvd       = 0;
        cyc        = 0;
        prev_stall = 1'b0;
        prev_obs   = '0;
        in_valid   = 1'b0;
        while (rcvd < N && cyc < 60000) begin
            if (!in_valid && sent < N && ($urandom % 4) != 0) begin
                in_valid = 1'b1;
                a        = rand_op();
                b        = rand_op();
            end
            out_ready = (($urandom % 4) != 0);
            total++;
            if (in_ready !== (q.size() < 2)) begin
                bad++;
                $display("FAIL rnd_ready cyc=%0d got=%b exp=%b", cyc, in_ready, q.size() < 2);
            end
            total++;
            if (out_valid !== (q.size() > 0)) begin
                bad++;
                $display("FAIL rnd_valid cyc=%0d got=%b exp=%b", cyc, out_valid, q.size() > 0);
            end
            if (prev_stall) begin
                total++;
                if (out_valid !== 1'b1 || obs !== prev_obs) begin
                    bad++;
                    $display("FAIL rnd_hold cyc=%0d got=%h exp=%h", cyc, obs, prev_obs);
                end
            end
            acc = in_valid && in_ready;
            pp  = out_valid && out_ready;
            if (pp) begin
                total++;
                if (q.size() == 0) begin
                    bad++;
                    $display("FAIL rnd_extra cyc=%0d got=%h exp=none", cyc, mask(obs));
                end else begin
                    exp_r = q.pop_front();
                    if (mask(obs) !== exp_r) begin
                        bad++;
                        $display("FAIL rnd_data n=%0d got=%h exp=%h", rcvd, mask(obs), exp_r);
                    end
                end
                rcvd++;
            end
            if (acc) begin
                q.push_back(model(a, b));
                sent++;
            end
            prev_stall = out_valid && !out_ready;
            prev_obs   = obs;
            step();
            if (acc) in_valid = 1'b0;
            cyc++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        total++;
        if (rcvd != N || sent != N || q.size() != 0) begin
            bad++;
            $display("FAIL rnd_complete got=%0d/%0d/%0d exp=%0d/%0d/0", sent, rcvd, q.size(), N, N);
        end
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;
        #1;
        test_reset();
        test_specials();
        test_back_to_back();
        test_reset_full();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
